hazard_sb: RTL and testbench
============================

Name: hazard_sb

Overview:
- Next-generation pipeline hazard controller for the 5-stage MIPS core.
- Adds three things to the existing forwarding and load-use/branch stall logic:
  - a HI/LO scoreboard, so the divider/multiplier (MDU) runs in the background instead of freezing E;
  - a parametrised load-use bubble counter, for multi-cycle data memory;
  - a global memory-stall input, with an exception flush deferred while that stall is active.
- Sits beside the datapath. Drives all stall/flush/forward selects.

Parameters:
- RW, 5, register-address width.
- LU_LAT, 1, load-use bubbles required (1..3); counter width is clog2(LU_LAT+1).
- BR_IN_D, 1, branch resolved in D; 1 enables D forwarding and branch stalls, 0 ties forwardaD/forwardbD/branch stall to 0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- rsD, rtD  in  RW  D source regs.
- branchD  in  1  branch in D.
- hilo_rdD  in  1  mfhi/mflo in D.
- mdu_opD  in  1  mult/div in D.
- rsE, rtE, writeregE  in  RW  E regs.
- regwriteE, memtoregE  in  1  E control.
- mdu_startE  in  1  MDU op leaving E this cycle.
- writeregM  in  RW  M dest.
- regwriteM, memtoregM, is_exceptM  in  1  M control.
- writeregW  in  RW  W dest.
- regwriteW  in  1  W control.
- mdu_done  in  1  MDU wrote HI/LO this cycle.
- mem_stall  in  1  I/D cache miss.
- stallF, stallD, stallE, stallM, stallW  out  1  stage holds.
- flushD, flushE, flushM  out  1  stage bubbles.
- forwardaD, forwardbD  out  1  D comparator from M.
- forwardaE, forwardbE  out  2  00 regfile, 01 W, 10 M.
- mdu_busy  out  1  HI/LO pending.
- mdu_cancel  out  1  abort in-flight MDU op.

Behaviour:
- One clock: clk. Reset: rst, asynchronous, active-high.
- Reset state: busy=0, lu_cnt=0, FSM=IDLE. With these states, all outputs are purely combinational and equal 0 when all inputs are 0.
- Forwarding (combinational):
  - E: M has priority over W; register 0 is never forwarded.
  - D: from M only, when regwriteM is set and the register is nonzero.
- lu_hit = memtoregE & writeregE!=0 & (writeregE==rsD | writeregE==rtD).
- On lu_hit with no higher-priority event, lu_cnt <= LU_LAT-1.
  - While lu_cnt!=0, D stays stalled and lu_cnt decrements each unstalled cycle.
  - So total bubbles = LU_LAT.
- br_hit = BR_IN_D & branchD & (regwriteE & writeregE∈{rsD,rtD} | memtoregM & writeregM∈{rsD,rtD}), with dest != 0.
- Scoreboard:
  - busy set on mdu_startE; cleared on mdu_done.
  - Simultaneous start and done: set wins.
  - mdu_busy = busy.
- hl_hit = (hilo_rdD | mdu_opD) & (busy | mdu_startE).
- dstall = lu_hit | lu_cnt!=0 | br_hit | hl_hit.
- FSM: IDLE, EXC_PEND.
  - IDLE with is_exceptM & mem_stall goes to EXC_PEND.
  - EXC_PEND waits for !mem_stall, then takes the flush and returns to IDLE.
  - The EXC_PEND flush does not re-check is_exceptM.
- exc_take = !mem_stall & (is_exceptM | state==EXC_PEND).
- Priority 1, mem_stall:
  - All five stalls = 1; all flushes = 0.
  - lu_cnt and busy updates from D hazards frozen; mdu_done still clears busy.
- Priority 2, exc_take:
  - flushD = flushE = flushM = 1; all stalls = 0.
  - lu_cnt <= 0; busy <= 0; mdu_cancel = 1 for that cycle.
  - mdu_startE in the same cycle is ignored.
- Priority 3, dstall: stallF = stallD = 1, flushE = 1; others 0.
- Otherwise all stall/flush outputs = 0.
- stallE/M/W are only ever asserted by mem_stall.
- mdu_cancel = 0 except under exc_take.
- Reset asserted mid-pend or mid-count returns to IDLE/0 immediately. No flush is issued for the pending exception.

Decomposition:
- Package hazard_pkg:
  - FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - FSM state encoding S_IDLE, S_EXC_PEND.
- Sub-module hazard_fwd (combinational, parameter RW): one source reg plus M/W dest/regwrite in, 2-bit select out. Instantiated for the E ports; D ports use its MEM-hit bit.

Test Plan:
- LU_LAT=2; lw $2 in E, add $3,$2,$1 in D → stallD=1/flushE=1 for exactly 2 cycles, then forwardaE=10 or 01 per stage of the load.
- mdu_startE=1 then mfhi in D for 5 cycles, mdu_done at cycle 5 → stallD high cycles 1–5, drops cycle 6; mdu_busy 1→0.
- is_exceptM=1 with mem_stall=1 for 3 cycles → no flush while stalled; flushD/E/M=1 and mdu_cancel=1 in the first cycle mem_stall=0; FSM back to IDLE.
- rsE=rtE=5, writeregM=writeregW=5, both regwrite → forwardaE=forwardbE=10; rsE=0 with writeregM=0 → 00.
- beq in D, addi $4 in E writing $4 = rsD → stallD=1, flushE=1; next cycle forwardaD=1, no stall.
- rst asserted asynchronously with lu_cnt=1 and busy=1 → all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: forwarding selects and
// the deferred-exception state machine states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_EXC_PEND = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_fwd.sv
// Forwarding select for one source register: M beats W, register 0 never forwards.
module hazard_fwd
  import hazard_pkg::*;
#(
  parameter int unsigned RW = 5
) (
  input  logic [RW-1:0] src,
  input  logic [RW-1:0] dst_m,
  input  logic          wr_m,
  input  logic [RW-1:0] dst_w,
  input  logic          wr_w,
  output logic [1:0]    sel
);

  always_comb begin
    sel = FWD_RF;
    if (src != RW'(0)) begin
      if (wr_m && (dst_m == src))      sel = FWD_MEM;
      else if (wr_w && (dst_w == src)) sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_sb.sv
// Pipeline hazard controller: forwarding, load-use/branch/HI-LO stalls,
// global memory stall and exception flush deferred across that stall.
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int unsigned RW      = 5,
  parameter int unsigned LU_LAT  = 1,
  parameter bit          BR_IN_D = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] rsD,
  input  logic [RW-1:0] rtD,
  input  logic          branchD,
  input  logic          hilo_rdD,
  input  logic          mdu_opD,
  input  logic [RW-1:0] rsE,
  input  logic [RW-1:0] rtE,
  input  logic [RW-1:0] writeregE,
  input  logic          regwriteE,
  input  logic          memtoregE,
  input  logic          mdu_startE,
  input  logic [RW-1:0] writeregM,
  input  logic          regwriteM,
  input  logic          memtoregM,
  input  logic          is_exceptM,
  input  logic [RW-1:0] writeregW,
  input  logic          regwriteW,
  input  logic          mdu_done,
  input  logic          mem_stall,
  output logic          stallF,
  output logic          stallD,
  output logic          stallE,
  output logic          stallM,
  output logic          stallW,
  output logic          flushD,
  output logic          flushE,
  output logic          flushM,
  output logic          forwardaD,
  output logic          forwardbD,
  output logic [1:0]    forwardaE,
  output logic [1:0]    forwardbE,
  output logic          mdu_busy,
  output logic          mdu_cancel
);

  localparam int unsigned LW = $clog2(LU_LAT + 1);

  state_t        state;
  logic          busy;
  logic [LW-1:0] lu_cnt;
  logic [1:0]    sel_aD, sel_bD;
  logic          lu_hit, br_hit, hl_hit, dstall, exc_take;
  logic          e_match, m_match;

  hazard_fwd #(.RW(RW)) u_fwd_aE (.src(rsE), .dst_m(writeregM), .wr_m(regwriteM),
                                  .dst_w(writeregW), .wr_w(regwriteW), .sel(forwardaE));
  hazard_fwd #(.RW(RW)) u_fwd_bE (.src(rtE), .dst_m(writeregM), .wr_m(regwriteM),
                                  .dst_w(writeregW), .wr_w(regwriteW), .sel(forwardbE));
  hazard_fwd #(.RW(RW)) u_fwd_aD (.src(rsD), .dst_m(writeregM), .wr_m(regwriteM),
                                  .dst_w(writeregW), .wr_w(regwriteW), .sel(sel_aD));
  hazard_fwd #(.RW(RW)) u_fwd_bD (.src(rtD), .dst_m(writeregM), .wr_m(regwriteM),
                                  .dst_w(writeregW), .wr_w(regwriteW), .sel(sel_bD));

  // D comparator only takes the M path; a W-only hit reads the regfile.
  assign forwardaD = BR_IN_D && (sel_aD == FWD_MEM);
  assign forwardbD = BR_IN_D && (sel_bD == FWD_MEM);

  assign e_match  = (writeregE != RW'(0)) && ((writeregE == rsD) || (writeregE == rtD));
  assign m_match  = (writeregM != RW'(0)) && ((writeregM == rsD) || (writeregM == rtD));
  assign lu_hit   = memtoregE && e_match;
  assign br_hit   = BR_IN_D && branchD && ((regwriteE && e_match) || (memtoregM && m_match));
  assign hl_hit   = (hilo_rdD || mdu_opD) && (busy || mdu_startE);
  assign dstall   = lu_hit || (lu_cnt != LW'(0)) || br_hit || hl_hit;
  assign exc_take = !mem_stall && (is_exceptM || (state == S_EXC_PEND));
  assign mdu_busy = busy;

  always_comb begin
    stallF     = 1'b0;
    stallD     = 1'b0;
    stallE     = 1'b0;
    stallM     = 1'b0;
    stallW     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    flushM     = 1'b0;
    mdu_cancel = 1'b0;
    if (mem_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      stallW = 1'b1;
    end else if (exc_take) begin
      flushD     = 1'b1;
      flushE     = 1'b1;
      flushM     = 1'b1;
      mdu_cancel = 1'b1;
    end else if (dstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  // Exception deferral, HI/LO scoreboard and load-use bubble counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      lu_cnt <= LW'(0);
    end else if (mem_stall) begin
      if (is_exceptM) state <= S_EXC_PEND;
      if (mdu_done)   busy  <= 1'b0;
    end else if (exc_take) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      lu_cnt <= LW'(0);
    end else begin
      if (mdu_startE)    busy <= 1'b1;
      else if (mdu_done) busy <= 1'b0;
      if (lu_hit)                 lu_cnt <= LW'(LU_LAT - 1);
      else if (lu_cnt != LW'(0))  lu_cnt <= lu_cnt - LW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_sb.sv
// Directed bench for hazard_sb with LU_LAT=2 and branch resolution in D.
module tb_hazard_sb;

  localparam int unsigned RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic          branchD, hilo_rdD, mdu_opD, regwriteE, memtoregE, mdu_startE;
  logic          regwriteM, memtoregM, is_exceptM, regwriteW, mdu_done, mem_stall;
  logic          stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM;
  logic          forwardaD, forwardbD, mdu_busy, mdu_cancel;
  logic [1:0]    forwardaE, forwardbE;
  logic [8:0]    ctrl;

  int tests = 0;
  int fails = 0;

  localparam logic [8:0] C_NONE  = 9'b000000000;
  localparam logic [8:0] C_DSTL  = 9'b110000100;
  localparam logic [8:0] C_MSTL  = 9'b111110000;
  localparam logic [8:0] C_EXC   = 9'b000001111;

  hazard_sb #(.RW(RW), .LU_LAT(2), .BR_IN_D(1'b1)) dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD),
    .hilo_rdD(hilo_rdD), .mdu_opD(mdu_opD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .regwriteE(regwriteE), .memtoregE(memtoregE),
    .mdu_startE(mdu_startE), .writeregM(writeregM), .regwriteM(regwriteM),
    .memtoregM(memtoregM), .is_exceptM(is_exceptM), .writeregW(writeregW),
    .regwriteW(regwriteW), .mdu_done(mdu_done), .mem_stall(mem_stall),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .stallW(stallW), .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE),
    .forwardbE(forwardbE), .mdu_busy(mdu_busy), .mdu_cancel(mdu_cancel)
  );

  always #5 clk = ~clk;

  assign ctrl = {stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, mdu_cancel};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeregE = '0; writeregM = '0; writeregW = '0;
    branchD = 0; hilo_rdD = 0; mdu_opD = 0; regwriteE = 0; memtoregE = 0;
    mdu_startE = 0; regwriteM = 0; memtoregM = 0; is_exceptM = 0;
    regwriteW = 0; mdu_done = 0; mem_stall = 0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #2;
    chk("reset_ctrl", 16'(ctrl), 16'(C_NONE));
    chk("reset_busy", 16'(mdu_busy), 16'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("idle_ctrl", 16'(ctrl), 16'(C_NONE));

    // E forwarding priority and register 0
    rsE = 5; rtE = 5; writeregM = 5; writeregW = 5; regwriteM = 1; regwriteW = 1;
    #1;
    chk("fwdaE_m_prio", 16'(forwardaE), 16'h2);
    chk("fwdbE_m_prio", 16'(forwardbE), 16'h2);
    regwriteM = 0;
    #1;
    chk("fwdaE_w", 16'(forwardaE), 16'h1);
    rsE = 0; writeregM = 0; regwriteM = 1;
    #1;
    chk("fwdaE_r0", 16'(forwardaE), 16'h0);
    // load to $0 never stalls
    clear_inputs();
    memtoregE = 1; regwriteE = 1; writeregE = 0;
    #1;
    chk("lu_r0_nostall", 16'(ctrl), 16'(C_NONE));

    // load-use: lw $2 in E, add $3,$2,$1 in D, two bubbles
    clear_inputs();
    rsD = 2; rtD = 1; memtoregE = 1; regwriteE = 1; writeregE = 2;
    #1;
    chk("lu_bubble1", 16'(ctrl), 16'(C_DSTL));
    tick();
    memtoregE = 0; regwriteE = 0; writeregE = 0;
    writeregM = 2; regwriteM = 1; memtoregM = 1;
    #1;
    chk("lu_bubble2", 16'(ctrl), 16'(C_DSTL));
    tick();
    rsE = 2; rtE = 1; rsD = 0; rtD = 0;
    writeregM = 0; regwriteM = 0; memtoregM = 0; writeregW = 2; regwriteW = 1;
    #1;
    chk("lu_release", 16'(ctrl), 16'(C_NONE));
    chk("lu_fwd_w", 16'(forwardaE), 16'h1);
    writeregM = 2; regwriteM = 1;
    #1;
    chk("lu_fwd_m", 16'(forwardaE), 16'h2);

    // HI/LO scoreboard: mult leaves E, mfhi waits in D until done
    tick();
    clear_inputs();
    mdu_startE = 1; hilo_rdD = 1;
    #1;
    chk("hl_c1_ctrl", 16'(ctrl), 16'(C_DSTL));
    chk("hl_c1_busy", 16'(mdu_busy), 16'h0);
    tick();
    mdu_startE = 0;
    for (int c = 2; c <= 4; c++) begin
      #1;
      chk("hl_mid_ctrl", 16'(ctrl), 16'(C_DSTL));
      chk("hl_mid_busy", 16'(mdu_busy), 16'h1);
      tick();
    end
    mdu_done = 1;
    #1;
    chk("hl_c5_ctrl", 16'(ctrl), 16'(C_DSTL));
    tick();
    mdu_done = 0;
    #1;
    chk("hl_c6_ctrl", 16'(ctrl), 16'(C_NONE));
    chk("hl_c6_busy", 16'(mdu_busy), 16'h0);
    hilo_rdD = 0;
    // start and done together: set wins
    mdu_startE = 1; mdu_done = 1;
    tick();
    mdu_startE = 0; mdu_done = 0;
    #1;
    chk("sb_set_wins", 16'(mdu_busy), 16'h1);

    // exception held off by mem_stall, then flushed without re-checking
    is_exceptM = 1; mem_stall = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("exc_stalled", 16'(ctrl), 16'(C_MSTL));
      tick();
    end
    chk("exc_busy_held", 16'(mdu_busy), 16'h1);
    mem_stall = 0; is_exceptM = 0;
    #1;
    chk("exc_flush", 16'(ctrl), 16'(C_EXC));
    tick();
    chk("exc_idle", 16'(ctrl), 16'(C_NONE));
    chk("exc_busy_clr", 16'(mdu_busy), 16'h0);

    // branch stall then D forwarding from M
    branchD = 1; rsD = 4; regwriteE = 1; writeregE = 4;
    #1;
    chk("br_stall", 16'(ctrl), 16'(C_DSTL));
    tick();
    regwriteE = 0; writeregE = 0; writeregM = 4; regwriteM = 1;
    #1;
    chk("br_release", 16'(ctrl), 16'(C_NONE));
    chk("br_fwdaD", 16'(forwardaD), 16'h1);
    chk("br_fwdbD", 16'(forwardbD), 16'h0);
    memtoregM = 1;
    #1;
    chk("br_load_m", 16'(ctrl), 16'(C_DSTL));
    tick();
    clear_inputs();

    // async reset with lu_cnt=1 and busy=1
    rsD = 2; memtoregE = 1; regwriteE = 1; writeregE = 2; mdu_startE = 1;
    tick();
    clear_inputs();
    #1;
    chk("pre_rst_ctrl", 16'(ctrl), 16'(C_DSTL));
    chk("pre_rst_busy", 16'(mdu_busy), 16'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_ctrl", 16'(ctrl), 16'(C_NONE));
    chk("async_rst_busy", 16'(mdu_busy), 16'h0);
    tick();
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
